frame_fifo_serializer: RTL and testbench

- Single-clock frame FIFO that sits between the sample-side packer and the UDP packetizer.
- Stores whole frames of DATA_POINTS words, each WIDTH bits wide.
- Replays each frame as a word-serial stream with first/last markers for the header/payload builder.
- Adds two things beyond the earlier buffer: selectable overflow policy (backpressure or drop-and-count) and an almost-full flag.

---
 rtl/frame_fifo_serializer_if.sv | 34 +++
 rtl/frame_fifo_serializer.sv | 137 +++++++++++++
 tb/tb_frame_fifo_serializer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_fifo_serializer_if.sv
// Frame-in / word-out handshake bundle for frame_fifo_serializer, plus its
// fill and drop status outputs.
interface frame_fifo_serializer_if #(
   parameter int WIDTH       = 9,
   parameter int DATA_POINTS = 5,
   parameter int DEPTH_LOG2  = 3
);
   logic                         drop_en;
   logic [DATA_POINTS*WIDTH-1:0] in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic [WIDTH-1:0]             out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_first;
   logic                         out_last;
   logic [DEPTH_LOG2:0]          fill_count;
   logic                         empty;
   logic                         full;
   logic                         almost_full;
   logic [15:0]                  drop_count;

   modport master (
      output drop_en, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_first, out_last,
             fill_count, empty, full, almost_full, drop_count
   );

   modport slave (
      input  drop_en, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_first, out_last,
             fill_count, empty, full, almost_full, drop_count
   );
endinterface

// File: rtl/frame_fifo_serializer.sv
// Whole-frame FIFO that replays each stored frame word-serially with
// first/last markers; full-FIFO policy is backpressure or drop-and-count.
module frame_fifo_serializer #(
   parameter int WIDTH        = 9,
   parameter int DATA_POINTS  = 5,
   parameter int DEPTH_LOG2   = 3,
   parameter int AFULL_THRESH = 6
) (
   input logic                 eth_clk,
   input logic                 rst,
   frame_fifo_serializer_if.slave bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int IDX_W = $clog2(DATA_POINTS);
   localparam int FC_W  = DEPTH_LOG2 + 1;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]      word_idx_q, word_idx_d;
   logic [FC_W-1:0]       fill_count_q, fill_count_d;
   logic [15:0]           drop_count_q, drop_count_d;

   logic [WIDTH-1:0]      mem_q [DEPTH][DATA_POINTS];

   logic empty_w, full_w, afull_w;
   logic in_ready_w, wr_en, drop_ev;
   logic out_valid_w, xfer, last_word, pop;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign empty_w = (fill_count_q == '0);
   assign full_w  = (fill_count_q == FC_W'(DEPTH));
   assign afull_w = (fill_count_q >= FC_W'(AFULL_THRESH));

   // A pop never frees a slot for a same-cycle write while full.
   assign in_ready_w = !rst && (!full_w || bus.drop_en);
   assign wr_en      = bus.in_valid && in_ready_w && !full_w;
   assign drop_ev    = bus.in_valid && in_ready_w && full_w;

   assign out_valid_w = !rst && !empty_w;
   assign xfer        = out_valid_w && bus.out_ready;
   assign last_word   = (word_idx_q == IDX_W'(DATA_POINTS - 1));
   assign pop         = xfer && last_word;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      word_idx_d   = word_idx_q;
      fill_count_d = fill_count_q;
      drop_count_d = drop_count_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (drop_ev) begin
         drop_count_d = sat_inc(drop_count_q);
      end

      if (wr_en && !pop) begin
         fill_count_d = fill_count_q + FC_W'(1);
      end else if (!wr_en && pop) begin
         fill_count_d = fill_count_q - FC_W'(1);
      end

      // STREAM is occupied exactly while the registered fill count is non-zero.
      unique case (state_q)
         IDLE: begin
            if (fill_count_d != '0) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (last_word) begin
                  word_idx_d = '0;
                  rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
               end else begin
                  word_idx_d = word_idx_q + IDX_W'(1);
               end
            end
            if (pop && fill_count_d == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge eth_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         word_idx_q   <= '0;
         fill_count_q <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         word_idx_q   <= word_idx_d;
         fill_count_q <= fill_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Frame storage carries no reset; only the pointers and counts define validity.
   always_ff @(posedge eth_clk) begin
      if (wr_en) begin
         for (int i = 0; i < DATA_POINTS; i++) begin
            mem_q[wr_ptr_q][i] <= bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.in_ready    = in_ready_w;
   assign bus.out_valid   = out_valid_w;
   assign bus.out_data    = mem_q[rd_ptr_q][word_idx_q];
   assign bus.out_first   = out_valid_w && (word_idx_q == '0);
   assign bus.out_last    = out_valid_w && last_word;
   assign bus.fill_count  = fill_count_q;
   assign bus.empty       = empty_w;
   assign bus.full        = full_w;
   assign bus.almost_full = afull_w;
   assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_frame_fifo_serializer.sv
// Directed bench for frame_fifo_serializer: reset, streaming, fill/drop,
// stall, steady-state write+pop and mid-frame reset.
module tb_frame_fifo_serializer;

   localparam int W  = 9;
   localparam int DP = 5;
   localparam int DL = 3;
   localparam int AT = 6;

   logic eth_clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 eth_clk = ~eth_clk;

   frame_fifo_serializer_if #(.WIDTH(W), .DATA_POINTS(DP), .DEPTH_LOG2(DL)) bus_if ();

   frame_fifo_serializer #(
      .WIDTH(W), .DATA_POINTS(DP), .DEPTH_LOG2(DL), .AFULL_THRESH(AT)
   ) dut (
      .eth_clk (eth_clk),
      .rst     (rst),
      .bus     (bus_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge eth_clk);
      #1;
   endtask

   // Word w of test frame f is {f[4:0], w[3:0]}.
   function automatic logic [W-1:0] word_of(input int f, input int w);
      return W'(((f % 32) * 16) + w);
   endfunction

   function automatic logic [DP*W-1:0] frame_of(input int f);
      logic [DP*W-1:0] r;
      r = '0;
      for (int w = 0; w < DP; w++) r[w*W +: W] = word_of(f, w);
      return r;
   endfunction

   task automatic chk_word(input string tag, input logic [W-1:0] exp, input int w);
      chk({tag, "_vld"},   32'(bus_if.out_valid), 32'd1);
      chk({tag, "_data"},  32'(bus_if.out_data),  32'(exp));
      chk({tag, "_first"}, 32'(bus_if.out_first), 32'(w == 0));
      chk({tag, "_last"},  32'(bus_if.out_last),  32'(w == DP - 1));
   endtask

   logic [W-1:0] t1 [DP];
   int           fc_exp;

   initial begin
      t1[0] = 9'h0F0; t1[1] = 9'h00F; t1[2] = 9'h0EE; t1[3] = 9'h0FF; t1[4] = 9'h0C0;
      rst = 1'b1;
      bus_if.drop_en   = 1'b0;
      bus_if.in_data   = '0;
      bus_if.in_valid  = 1'b1;
      bus_if.out_ready = 1'b0;

      // Reset state
      repeat (3) step();
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus_if.in_ready),  32'd0);
      chk("rst_first",     32'(bus_if.out_first), 32'd0);
      chk("rst_last",      32'(bus_if.out_last),  32'd0);
      bus_if.in_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("rel_empty", 32'(bus_if.empty),       32'd1);
      chk("rel_full",  32'(bus_if.full),        32'd0);
      chk("rel_afull", 32'(bus_if.almost_full), 32'd0);
      chk("rel_fill",  32'(bus_if.fill_count),  32'd0);
      chk("rel_drop",  32'(bus_if.drop_count),  32'd0);
      chk("rel_ready", 32'(bus_if.in_ready),    32'd1);

      // Single frame streamed with out_ready held high
      bus_if.out_ready = 1'b1;
      for (int w = 0; w < DP; w++) bus_if.in_data[w*W +: W] = t1[w];
      bus_if.in_valid = 1'b1;
      step();
      bus_if.in_valid = 1'b0;
      for (int w = 0; w < DP; w++) begin
         chk_word("single", t1[w], w);
         chk("single_fill", 32'(bus_if.fill_count), 32'd1);
         step();
      end
      chk("single_empty", 32'(bus_if.empty),      32'd1);
      chk("single_fill0", 32'(bus_if.fill_count), 32'd0);
      chk("single_vld0",  32'(bus_if.out_valid),  32'd0);

      // Fill to full under backpressure
      bus_if.out_ready = 1'b0;
      for (int f = 0; f < 8; f++) begin
         bus_if.in_data  = frame_of(f);
         bus_if.in_valid = 1'b1;
         step();
         chk("fill_count", 32'(bus_if.fill_count),  32'(f + 1));
         chk("fill_afull", 32'(bus_if.almost_full), 32'(f + 1 >= AT));
         chk("fill_full",  32'(bus_if.full),        32'(f + 1 == 8));
      end
      chk("full_in_ready", 32'(bus_if.in_ready), 32'd0);
      bus_if.in_data = frame_of(9);
      step();
      chk("ninth_fill", 32'(bus_if.fill_count), 32'd8);
      chk("ninth_drop", 32'(bus_if.drop_count), 32'd0);
      bus_if.in_valid = 1'b0;

      // Drop mode while full
      bus_if.drop_en = 1'b1;
      #1;
      chk("drop_in_ready", 32'(bus_if.in_ready), 32'd1);
      for (int j = 0; j < 3; j++) begin
         bus_if.in_data  = frame_of(20 + j);
         bus_if.in_valid = 1'b1;
         step();
      end
      bus_if.in_valid = 1'b0;
      chk("drop_count", 32'(bus_if.drop_count), 32'd3);
      chk("drop_fill",  32'(bus_if.fill_count), 32'd8);
      bus_if.drop_en = 1'b0;

      // Drain the first 8 frames, stalling 4 cycles on word 2 of frame 0
      bus_if.out_ready = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int w = 0; w < DP; w++) begin
            if (f == 0 && w == 2) begin
               bus_if.out_ready = 1'b0;
               repeat (4) begin
                  step();
                  chk("stall_data",  32'(bus_if.out_data),  32'(word_of(0, 2)));
                  chk("stall_first", 32'(bus_if.out_first), 32'd0);
                  chk("stall_last",  32'(bus_if.out_last),  32'd0);
               end
               bus_if.out_ready = 1'b1;
            end
            if (w == 0) chk("drain_fill", 32'(bus_if.fill_count), 32'(8 - f));
            chk_word("drain", word_of(f, w), w);
            step();
         end
      end
      chk("drain_empty", 32'(bus_if.empty), 32'd1);

      // Steady state: write on every pop with three frames resident
      bus_if.out_ready = 1'b0;
      for (int f = 0; f < 3; f++) begin
         bus_if.in_data  = frame_of(30 + f);
         bus_if.in_valid = 1'b1;
         step();
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      for (int n = 0; n < 23; n++) begin
         fc_exp = 3 + ((n < 20) ? n : 20) - n;
         for (int w = 0; w < DP; w++) begin
            chk_word("thru", word_of(30 + n, w), w);
            chk("thru_fill", 32'(bus_if.fill_count), 32'(fc_exp));
            if (w == DP - 1 && n < 20) begin
               bus_if.in_data  = frame_of(33 + n);
               bus_if.in_valid = 1'b1;
            end else begin
               bus_if.in_valid = 1'b0;
            end
            step();
         end
      end
      bus_if.in_valid = 1'b0;
      chk("thru_empty", 32'(bus_if.empty), 32'd1);

      // Reset during word 3 of a frame
      bus_if.in_data  = frame_of(60);
      bus_if.in_valid = 1'b1;
      step();
      bus_if.in_valid = 1'b0;
      for (int w = 0; w < 3; w++) begin
         chk_word("prerst", word_of(60, w), w);
         step();
      end
      chk_word("prerst", word_of(60, 3), 3);
      rst = 1'b1;
      #1;
      chk("inrst_ready", 32'(bus_if.in_ready),  32'd0);
      chk("inrst_vld",   32'(bus_if.out_valid), 32'd0);
      step();
      chk("postrst_vld",  32'(bus_if.out_valid),  32'd0);
      chk("postrst_fill", 32'(bus_if.fill_count), 32'd0);
      chk("postrst_drop", 32'(bus_if.drop_count), 32'd0);
      rst = 1'b0;
      step();
      chk("relrst_vld",   32'(bus_if.out_valid), 32'd0);
      chk("relrst_empty", 32'(bus_if.empty),     32'd1);
      bus_if.in_data  = frame_of(61);
      bus_if.in_valid = 1'b1;
      step();
      bus_if.in_valid = 1'b0;
      for (int w = 0; w < DP; w++) begin
         chk_word("after_rst", word_of(61, w), w);
         step();
      end
      chk("after_rst_empty", 32'(bus_if.empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
